// File: rtl/hdmi_i2c_config_sequencer.sv
// HDMI transmitter configuration sequencer.
// Walks a fixed register table after power-up and issues one
// {slave, reg, data} word per I2C write. NACKed or timed-out writes are
// retried. Overall status is reported on cfg_busy/cfg_done/cfg_error.
// Optional macro CFG_HPD_REINIT_EN: a synchronized rising edge on hpd
// reruns the table from S_DONE/S_ERROR, like start_cfg.
module hdmi_i2c_config_sequencer #(
    parameter logic [7:0]  SLAVE_ADDR     = 8'h72,
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned POWERUP_CYCLES = 1_000_000,
    parameter int unsigned GAP_CYCLES     = 500,
    parameter int unsigned TIMEOUT_CYCLES = 100_000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned CNT_W          = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_cfg,
    input  logic        hpd,
    input  logic        i2c_busy,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        i2c_start,
    output logic [23:0] i2c_data,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [4:0]  cfg_index
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned RTY_W = 8;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc_c;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RTY_W-1:0]   rty_q, rty_d;
    logic               start_q, start_d;
    logic [23:0]        data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [15:0]        entry_c;
    logic               restart_c;

    // Register table: {reg_addr, reg_data} per index; unused slots read zero.
    function automatic logic [15:0] table_entry(input logic [IDX_W-1:0] idx);
        case (idx)
            5'd0:    return 16'h4110;
            5'd1:    return 16'h9803;
            5'd2:    return 16'h9AE0;
            5'd3:    return 16'h9C30;
            5'd4:    return 16'h9D61;
            5'd5:    return 16'hA2A4;
            5'd6:    return 16'hA3A4;
            5'd7:    return 16'hE0D0;
            5'd8:    return 16'hF900;
            5'd9:    return 16'h1500;
            5'd10:   return 16'h1630;
            5'd11:   return 16'h1702;
            5'd12:   return 16'h1846;
            5'd13:   return 16'hAF04;
            5'd14:   return 16'h9620;
            5'd15:   return 16'h5500;
            default: return 16'h0000;
        endcase
    endfunction

    assign entry_c   = table_entry(idx_q);
    assign cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef CFG_HPD_REINIT_EN
    logic [2:0] hpd_q;
    logic       hpd_rise_c;

    // Two-flop synchronizer plus one delay flop for rising-edge detect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hpd_q <= 3'b000;
        end else begin
            hpd_q <= {hpd_q[1:0], hpd};
        end
    end

    assign hpd_rise_c = hpd_q[1] & ~hpd_q[2];
    assign restart_c  = start_cfg | hpd_rise_c;
`else
    logic unused_hpd;
    assign unused_hpd = hpd;
    assign restart_c  = start_cfg;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            rty_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rty_q   <= rty_d;
            start_q <= start_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state, counter, retry bookkeeping and registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc_c;
        idx_d   = idx_q;
        rty_d   = rty_q;
        start_d = 1'b0;
        data_d  = data_q;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == CNT_W'(POWERUP_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                data_d = {SLAVE_ADDR, entry_c};
                if (!i2c_busy) begin
                    start_d = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (i2c_done && !i2c_nack) begin
                    rty_d = '0;
                    if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end
                end else if (i2c_done || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    if (rty_q < RTY_W'(MAX_RETRY)) begin
                        rty_d   = rty_q + RTY_W'(1);
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end
            end
            S_DONE, S_ERROR: begin
                if (restart_c) begin
                    idx_d   = '0;
                    rty_d   = '0;
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = '0;
            end
        endcase

        busy_d = !((state_d == S_DONE) || (state_d == S_ERROR));
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

    assign i2c_start = start_q;
    assign i2c_data  = data_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_error = err_q;
    assign cfg_index = idx_q;

endmodule

// File: tb/tb_hdmi_i2c_config_sequencer.sv
// Self-checking bench for hdmi_i2c_config_sequencer: a transaction-level
// model of the sequencer checked every cycle, an I2C slave responder with
// selectable NACK/hang/busy-hold behaviour, and directed literal checks.
module tb_hdmi_i2c_config_sequencer;

    localparam int PWR  = 100;
    localparam int GAP  = 20;
    localparam int TO   = 50;
    localparam int MR   = 3;
    localparam int NUM  = 16;
    localparam logic [15:0] TBL [0:15] = '{
        16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4, 16'hA3A4, 16'hE0D0,
        16'hF900, 16'h1500, 16'h1630, 16'h1702, 16'h1846, 16'hAF04, 16'h9620, 16'h5500};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_cfg = 1'b0;
    logic        hpd = 1'b0;
    logic        i2c_busy = 1'b0;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        i2c_start;
    logic [23:0] i2c_data;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_error;
    logic [4:0]  cfg_index;

    hdmi_i2c_config_sequencer #(
        .POWERUP_CYCLES(PWR),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_cfg(start_cfg),
        .hpd      (hpd),
        .i2c_busy (i2c_busy),
        .i2c_done (i2c_done),
        .i2c_nack (i2c_nack),
        .i2c_start(i2c_start),
        .i2c_data (i2c_data),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_error(cfg_error),
        .cfg_index(cfg_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder policy (written by the stimulus only).
    logic [7:0] pol_nack_addr = 8'hFF;
    int         pol_nack_n    = 0;
    logic [7:0] pol_hang_addr = 8'hFF;
    logic [7:0] pol_hold_addr = 8'hFF;
    int         pol_hold_n    = 0;
    int         pol_epoch     = 0;
    int         hold_done_cyc = 0;

    // I2C slave: busy after a start, done 5 cycles later, optional NACK/hang/busy hold.
    initial begin
        int seen_epoch;
        int nack_given;
        logic [7:0] a;
        logic nk;
        seen_epoch = 0;
        nack_given = 0;
        forever begin
            @(negedge clk);
            if (pol_epoch != seen_epoch) begin
                seen_epoch = pol_epoch;
                nack_given = 0;
            end
            if (i2c_start && (i2c_data[15:8] != pol_hang_addr)) begin
                a = i2c_data[15:8];
                @(posedge clk); #1 i2c_busy = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                nk = (a == pol_nack_addr) && (nack_given < pol_nack_n);
                if (nk) nack_given++;
                i2c_done = 1'b1;
                i2c_nack = nk;
                if (a == pol_hold_addr) hold_done_cyc = cyc + 1;
                @(posedge clk); #1;
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
                if (a == pol_hold_addr) begin
                    repeat (pol_hold_n) @(posedge clk);
                    #1;
                end
                i2c_busy = 1'b0;
            end
        end
    end

    // Checking state.
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Transaction-level model: phase 0=configuring, 1=all acked, 2=gave up.
    int   ph = 0, m_idx = 0, m_rty = 0, m_nxt = 0, m_ws = 0;
    bit   m_wait = 1'b0, exp_st = 1'b0;
    logic e_rst = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_nack = 1'b0, e_scfg = 1'b0;

    // Start statistics.
    int          tot_starts = 0, last_start_cyc = 0, last_9c_cyc = 0;
    logic [23:0] last_start_data = '0;
    int          n_4110 = 0, n_9ae0 = 0, n_a2a4 = 0, n_9c30 = 0, n_e0d0 = 0;

    task automatic model_step();
        exp_st = 1'b0;
        if (!e_rst) begin
            ph = 0; m_idx = 0; m_rty = 0; m_wait = 1'b0; m_nxt = cyc + PWR + 1;
        end else if (ph == 0) begin
            if (m_wait) begin
                if (e_done || (cyc == m_ws + TO)) begin
                    m_wait = 1'b0;
                    if (e_done && !e_nack) begin
                        m_rty = 0;
                        if (m_idx == NUM - 1) ph = 1;
                        else begin m_idx++; m_nxt = cyc + GAP + 1; end
                    end else if (m_rty < MR) begin
                        m_rty++; m_nxt = cyc + GAP + 1;
                    end else begin
                        ph = 2;
                    end
                end
            end else if ((cyc >= m_nxt) && !e_busy) begin
                exp_st = 1'b1; m_wait = 1'b1; m_ws = cyc;
            end
        end else if (e_scfg) begin
            ph = 0; m_idx = 0; m_rty = 0; m_nxt = cyc + GAP + 1;
        end

        chk("i2c_start", 32'(i2c_start), 32'(exp_st));
        chk("cfg_busy",  32'(cfg_busy),  32'(ph == 0));
        chk("cfg_done",  32'(cfg_done),  32'(ph == 1));
        chk("cfg_error", 32'(cfg_error), 32'(ph == 2));
        chk("cfg_index", 32'(cfg_index), 32'(m_idx));
        if (m_wait) chk("i2c_data", 32'(i2c_data), {8'h0, 8'h72, TBL[m_idx]});
        if (!e_rst) chk("i2c_data_rst", 32'(i2c_data), 32'h0);

        if (i2c_start) begin
            tot_starts++;
            last_start_cyc  = cyc;
            last_start_data = i2c_data;
            if (i2c_data == 24'h724110) n_4110++;
            if (i2c_data == 24'h729AE0) n_9ae0++;
            if (i2c_data == 24'h72A2A4) n_a2a4++;
            if (i2c_data == 24'h72E0D0) n_e0d0++;
            if (i2c_data == 24'h729C30) begin n_9c30++; last_9c_cyc = cyc; end
        end

        e_rst = reset_n; e_busy = i2c_busy; e_done = i2c_done;
        e_nack = i2c_nack; e_scfg = start_cfg;
    endtask

    task automatic wait_end(input int lim, input string nm);
        int n;
        n = 0;
        while (!cfg_done && !cfg_error && (n < lim)) begin @(negedge clk); n++; end
        chk(nm, 32'(cfg_done | cfg_error), 32'd1);
    endtask

    task automatic wait_start(input int s0, input int lim, input string nm);
        int n;
        n = 0;
        while ((tot_starts == s0) && (n < lim)) begin @(negedge clk); n++; end
        chk(nm, 32'(tot_starts != s0), 32'd1);
    endtask

    task automatic pulse_start(output int sc);
        @(posedge clk); #1 start_cfg = 1'b1; sc = cyc + 1;
        @(posedge clk); #1 start_cfg = 1'b0;
    endtask

    task automatic run_tests();
        int rel, s0, sc, c1, k;
        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(i2c_start), 32'd0);
        chk("rst_data",  32'(i2c_data),  32'd0);
        chk("rst_busy",  32'(cfg_busy),  32'd1);
        chk("rst_done",  32'(cfg_done),  32'd0);
        chk("rst_error", 32'(cfg_error), 32'd0);
        chk("rst_index", 32'(cfg_index), 32'd0);

        // All ACK.
        @(posedge clk); #1 reset_n = 1'b1; rel = cyc + 1; s0 = tot_starts;
        wait_start(s0, 300, "t1_first_start_seen");
        chk("t1_pwrup_latency", 32'(last_start_cyc - rel), 32'd100);
        chk("t1_first_word", 32'(last_start_data), 32'h724110);
        wait_end(3000, "t1_finished");
        chk("t1_done", 32'(cfg_done), 32'd1);
        chk("t1_error", 32'(cfg_error), 32'd0);
        chk("t1_busy", 32'(cfg_busy), 32'd0);
        chk("t1_starts", 32'(tot_starts - s0), 32'd16);
        chk("t1_last_word", 32'(last_start_data), 32'h725500);

        // NACK entry 2 twice.
        pol_nack_addr = 8'h9A; pol_nack_n = 2; pol_epoch++;
        k = n_9ae0;
        pulse_start(sc);
        wait_end(3000, "t2_finished");
        chk("t2_entry2_starts", 32'(n_9ae0 - k), 32'd3);
        chk("t2_done", 32'(cfg_done), 32'd1);

        // NACK entry 5 forever.
        pol_nack_addr = 8'hA2; pol_nack_n = 99; pol_epoch++;
        k = n_a2a4;
        pulse_start(sc);
        wait_end(3000, "t3_finished");
        chk("t3_error", 32'(cfg_error), 32'd1);
        chk("t3_done", 32'(cfg_done), 32'd0);
        chk("t3_index", 32'(cfg_index), 32'd5);
        chk("t3_entry5_starts", 32'(n_a2a4 - k), 32'd4);
        s0 = tot_starts;
        repeat (200) @(negedge clk);
        chk("t3_no_more_starts", 32'(tot_starts - s0), 32'd0);

        // Entry 0 never answered: timeouts.
        pol_nack_addr = 8'hFF; pol_hang_addr = 8'h41; pol_epoch++;
        k = n_4110; s0 = tot_starts;
        pulse_start(sc);
        wait_start(s0, 100, "t4_first_start_seen");
        c1 = last_start_cyc;
        chk("t4_first_latency", 32'(c1 - sc), 32'(GAP + 1));
        wait_end(2000, "t4_finished");
        chk("t4_error", 32'(cfg_error), 32'd1);
        chk("t4_index", 32'(cfg_index), 32'd0);
        chk("t4_attempts", 32'(n_4110 - k), 32'd4);
        chk("t4_retry_spacing", 32'(last_start_cyc - c1), 32'(3 * (TO + GAP + 1)));

        // Busy held across the issue of entry 3.
        pol_hang_addr = 8'hFF; pol_hold_addr = 8'h9A; pol_hold_n = GAP + 30; pol_epoch++;
        k = n_9c30;
        pulse_start(sc);
        wait_end(3000, "t5_finished");
        chk("t5_done", 32'(cfg_done), 32'd1);
        chk("t5_entry3_starts", 32'(n_9c30 - k), 32'd1);
        chk("t5_busy_delay", 32'(last_9c_cyc - hold_done_cyc), 32'(GAP + 31));

        // Reset mid-sequence at entry 7, then rerun without power-up wait.
        pol_hold_addr = 8'hFF; pol_hold_n = 0; pol_epoch++;
        k = n_e0d0;
        pulse_start(sc);
        begin
            int n;
            n = 0;
            while ((n_e0d0 == k) && (n < 1000)) begin @(negedge clk); n++; end
            chk("t6_entry7_reached", 32'(n_e0d0 != k), 32'd1);
        end
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1; rel = cyc + 1; s0 = tot_starts;
        wait_start(s0, 300, "t6_first_start_seen");
        chk("t6_pwrup_latency", 32'(last_start_cyc - rel), 32'd100);
        chk("t6_first_word", 32'(last_start_data), 32'h724110);
        wait_end(3000, "t6_finished");
        chk("t6_done", 32'(cfg_done), 32'd1);
        s0 = tot_starts;
        pulse_start(sc);
        wait_start(s0, 100, "t6_rerun_start_seen");
        chk("t6_rerun_latency", 32'(last_start_cyc - sc), 32'(GAP + 1));
        chk("t6_rerun_word", 32'(last_start_data), 32'h724110);
        wait_end(3000, "t6_rerun_finished");
        chk("t6_rerun_done", 32'(cfg_done), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                model_step();
            end
            run_tests();
        join_any
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
